sc_obc_sysreg_axil: RTL
=======================

Name: sc_obc_sysreg_axil

Overview:
- AXI4-Lite responder (slave) in the PL for the Versal PS master port.
- Gives PS software a system register file: version, scratch, control outputs, status inputs, and edge-captured interrupts with one level IRQ back to the PS.
- Sits under the top level, beside the PS block design, on the PL-side AXI master clock.

Parameters:
- ADDR_W, 8, AXI address width. Decode uses bits [ADDR_W-1:2]; bits [1:0] are ignored.
- VERSION, 32'h0001_0000, reset and constant value of the VERSION register.
- NUM_IRQ, 8, number of interrupt input lines (1..32).
- CTRL_RST, 32'h0000_0000, reset value of the CONTROL register.

Ports:
- CLK  in  1  single clock for all logic.
- RESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  ADDR_W;  S_AXI_AWVALID  in  1;  S_AXI_AWREADY  out  1  (write address channel).
- S_AXI_WDATA  in  32;  S_AXI_WSTRB  in  4;  S_AXI_WVALID  in  1;  S_AXI_WREADY  out  1  (write data channel).
- S_AXI_BRESP  out  2;  S_AXI_BVALID  out  1;  S_AXI_BREADY  in  1  (write response channel).
- S_AXI_ARADDR  in  ADDR_W;  S_AXI_ARVALID  in  1;  S_AXI_ARREADY  out  1  (read address channel).
- S_AXI_RDATA  out  32;  S_AXI_RRESP  out  2;  S_AXI_RVALID  out  1;  S_AXI_RREADY  in  1  (read data channel).
- CTRL_OUT  out  32  CONTROL register contents.
- STATUS_IN  in  32  live status, synchronous to CLK.
- IRQ_IN  in  NUM_IRQ  interrupt sources, synchronous to CLK, rising-edge sensitive.
- IRQ  out  1  level interrupt to the PS.

Behaviour:
- Clocking and reset: one clock (CLK). Reset (RESET) is synchronous and active-high.
- Register map (byte offsets):
  - 0x00 VERSION: RO.
  - 0x04 SCRATCH: RW, reset 0.
  - 0x08 CONTROL: RW, reset CTRL_RST.
  - 0x0C STATUS: RO, returns STATUS_IN sampled on the AR handshake.
  - 0x10 IRQ_STAT: W1C, reset 0.
  - 0x14 IRQ_EN: RW, reset 0.
  - 0x18 UPTIME: optional, see below.
- Unused bits at or above NUM_IRQ in IRQ_STAT and IRQ_EN read 0.
- Reset values: all READY/VALID outputs 0, BRESP/RRESP 0, RDATA 0, IRQ 0, internal AW/W holding buffers empty.
- Write path:
  - AW and W are accepted independently. AWREADY = AW buffer empty; WREADY = W buffer empty.
  - Commit happens in the cycle both buffers are full and (!BVALID or BREADY). On that edge: the register updates, both buffers clear, BVALID goes to 1.
  - AW and W handshakes at edge N give commit and BVALID at edge N+1. Only one write is outstanding.
  - BVALID holds until BREADY.
- WSTRB: byte lanes are honoured for SCRATCH, CONTROL and IRQ_EN. For IRQ_STAT, only bytes with their strobe set clear bits.
- Write responses: OKAY (2'b00) for RW and W1C registers. SLVERR (2'b10) for RO or unmapped offsets; these writes have no side effect.
- Read path:
  - ARREADY = !RVALID.
  - AR handshake at edge N: RDATA, RRESP and RVALID are registered at edge N, i.e. visible in cycle N+1.
  - RDATA and RRESP are stable while RVALID=1 and RREADY=0.
  - Unmapped offsets return RDATA=0 with RRESP=SLVERR.
- Simultaneous read and write to the same register: the read returns the pre-write value.
- Interrupts:
  - IRQ_IN is registered once for edge detection. A 0→1 edge sets the corresponding IRQ_STAT bit.
  - Set and W1C clear of the same bit in the same cycle: set wins.
  - IRQ = registered |(IRQ_STAT & IRQ_EN), asserted one cycle after the stat/enable change.
  - IRQ_IN held high after a clear does not re-set the bit; a new edge is required.
- Reset mid-transaction: all buffers and VALIDs drop the next cycle and pending responses are discarded. The master is required to be reset in the same domain.

Optional Feature:
- Macro: SC_OBC_SYSREG_UPTIME_EN.
- Defined:
  - 0x18 UPTIME is a 32-bit free-running counter, reset 0, incrementing every CLK and wrapping 0xFFFF_FFFF→0.
  - Any write to UPTIME (OKAY response) clears it to 0 on the commit edge. Write data is ignored.
- Undefined: 0x18 is unmapped (reads 0 with SLVERR; writes SLVERR) and the counter logic is absent.

Decomposition:
- Package sc_obc_sysreg_pkg holds:
  - register offset localparams (OFS_VERSION .. OFS_UPTIME);
  - AXI response codes RESP_OKAY and RESP_SLVERR;
  - a byte-strobe merge function.
- One sub-module: sc_obc_irq_capture (parameter NUM_IRQ). It contains the edge detector, the sticky IRQ_STAT with set-over-clear priority, the enable masking and the registered IRQ output.

Test Plan:
- Write SCRATCH: AW+W same cycle, addr 0x04, data 0xDEADBEEF, WSTRB 0xF → BVALID one cycle later with BRESP 0. Read of 0x04 → RVALID the cycle after ARVALID, RDATA 0xDEADBEEF, RRESP 0.
- Split channels: W given 3 cycles before AW, data 0x12345678, WSTRB 4'b0011, to CONTROL (0x08) → CTRL_OUT=0x00005678. Hold BREADY=0 for 4 cycles → BVALID stays 1, and a second AW is buffered but not committed until the B handshake.
- Bad targets: write to VERSION 0x00 → BRESP 2'b10 and VERSION unchanged. Read of 0x1C → RDATA 0, RRESP 2'b10.
- Interrupts: IRQ_EN=0x01, pulse IRQ_IN[0] → IRQ_STAT=0x01 and IRQ=1. Write 0x01 to 0x10 in the same cycle as a new IRQ_IN[0] edge → bit stays 1. Clear again with no edge → IRQ=0 one cycle later.
- Back-pressure: RREADY=0 for 5 cycles after a read of STATUS → RDATA is held and ARREADY=0. Change STATUS_IN meanwhile → RDATA unchanged.
- With SC_OBC_SYSREG_UPTIME_EN defined: read 0x18 twice 10 cycles apart → difference 10. Write 0x18 → next read returns a small value (≤3). Without the macro → read of 0x18 returns SLVERR.

Source files
------------

// File: rtl/sc_obc_sysreg_pkg.sv
// Shared definitions for the OBC system register block.
// Holds the register byte offsets, the AXI response codes and the byte-strobe helpers.
package sc_obc_sysreg_pkg;

   localparam int unsigned OFS_VERSION  = 32'h00;
   localparam int unsigned OFS_SCRATCH  = 32'h04;
   localparam int unsigned OFS_CONTROL  = 32'h08;
   localparam int unsigned OFS_STATUS   = 32'h0C;
   localparam int unsigned OFS_IRQ_STAT = 32'h10;
   localparam int unsigned OFS_IRQ_EN   = 32'h14;
   localparam int unsigned OFS_UPTIME   = 32'h18;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Expand a 4-bit byte strobe into a 32-bit bit mask.
   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) begin
         m[8*i +: 8] = {8{strb[i]}};
      end
      return m;
   endfunction

   // Replace only the strobed byte lanes of cur with wdata.
   function automatic logic [31:0] strb_merge(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
      logic [31:0] m;
      m = strb_mask(strb);
      return (cur & ~m) | (wdata & m);
   endfunction

endpackage

// File: rtl/sc_obc_irq_capture.sv
// Edge-captured interrupt status with enable masking and a registered level IRQ.
// Ports: clk/reset (sync, active high); irq_in raw sources; clr W1C mask (already
// gated by the write commit); en enable mask; stat sticky status; irq level output.
module sc_obc_irq_capture #(
   parameter int unsigned NUM_IRQ = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic [NUM_IRQ-1:0] clr,
   input  logic [NUM_IRQ-1:0] en,
   output logic [NUM_IRQ-1:0] stat,
   output logic               irq
);

   logic [NUM_IRQ-1:0] irq_q;

   // A new rising edge is OR-ed in after the clear, so set beats clear in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_q <= '0;
         stat  <= '0;
         irq   <= 1'b0;
      end else begin
         irq_q <= irq_in;
         stat  <= (stat & ~clr) | (irq_in & ~irq_q);
         irq   <= |(stat & en);
      end
   end

endmodule

// File: rtl/sc_obc_sysreg_axil.sv
// AXI4-Lite system register file for the PS: VERSION, SCRATCH, CONTROL, STATUS,
// IRQ_STAT (W1C), IRQ_EN and, with SC_OBC_SYSREG_UPTIME_EN defined, UPTIME at 0x18.
// Ports: CLK/RESET (sync, active high); S_AXI_* AXI4-Lite responder; CTRL_OUT control
// register; STATUS_IN live status; IRQ_IN rising-edge sources; IRQ level interrupt.
module sc_obc_sysreg_axil
   import sc_obc_sysreg_pkg::*;
#(
   parameter int unsigned ADDR_W   = 8,
   parameter logic [31:0] VERSION  = 32'h0001_0000,
   parameter int unsigned NUM_IRQ  = 8,
   parameter logic [31:0] CTRL_RST = 32'h0000_0000
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [ADDR_W-1:0]  S_AXI_AWADDR,
   input  logic               S_AXI_AWVALID,
   output logic               S_AXI_AWREADY,
   input  logic [31:0]        S_AXI_WDATA,
   input  logic [3:0]         S_AXI_WSTRB,
   input  logic               S_AXI_WVALID,
   output logic               S_AXI_WREADY,
   output logic [1:0]         S_AXI_BRESP,
   output logic               S_AXI_BVALID,
   input  logic               S_AXI_BREADY,
   input  logic [ADDR_W-1:0]  S_AXI_ARADDR,
   input  logic               S_AXI_ARVALID,
   output logic               S_AXI_ARREADY,
   output logic [31:0]        S_AXI_RDATA,
   output logic [1:0]         S_AXI_RRESP,
   output logic               S_AXI_RVALID,
   input  logic               S_AXI_RREADY,
   output logic [31:0]        CTRL_OUT,
   input  logic [31:0]        STATUS_IN,
   input  logic [NUM_IRQ-1:0] IRQ_IN,
   output logic               IRQ
);

   localparam int unsigned IDX_W = ADDR_W - 2;

   // Word-index match against a byte offset; address bits [1:0] never take part.
   function automatic logic hit(input logic [IDX_W-1:0] idx, input int unsigned ofs);
      return idx == IDX_W'(ofs >> 2);
   endfunction

   logic               aw_full, w_full;
   logic [IDX_W-1:0]   aw_idx;
   logic [31:0]        w_data;
   logic [3:0]         w_strb;
   logic [31:0]        scratch, control;
   logic [NUM_IRQ-1:0] irq_en, irq_stat, irq_clr_c;
   logic               aw_hs_c, w_hs_c, ar_hs_c, commit_c;
   logic               aw_full_nx_c, w_full_nx_c, bvalid_nx_c, rvalid_nx_c;
   logic [1:0]         wr_resp_c, rd_resp_c;
   logic [31:0]        rd_data_c;
   logic [IDX_W-1:0]   ar_idx_c;
   logic               wr_scratch_c, wr_control_c, wr_irq_en_c, wr_irq_stat_c;
   logic               unused_addr_lsb;
`ifdef SC_OBC_SYSREG_UPTIME_EN
   logic [31:0]        uptime;
   logic               wr_uptime_c;
`endif

   assign unused_addr_lsb = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
   assign CTRL_OUT        = control;

   // Handshakes and next state of the channel flags; one write outstanding at a time.
   always_comb begin
      aw_hs_c      = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs_c       = S_AXI_WVALID && S_AXI_WREADY;
      ar_hs_c      = S_AXI_ARVALID && S_AXI_ARREADY;
      commit_c     = aw_full && w_full && (!S_AXI_BVALID || S_AXI_BREADY);
      aw_full_nx_c = commit_c ? 1'b0 : (aw_full || aw_hs_c);
      w_full_nx_c  = commit_c ? 1'b0 : (w_full || w_hs_c);
      bvalid_nx_c  = commit_c || (S_AXI_BVALID && !S_AXI_BREADY);
      rvalid_nx_c  = ar_hs_c || (S_AXI_RVALID && !S_AXI_RREADY);
   end

   // Write decode of the buffered address; enables are qualified by the commit.
   always_comb begin
      wr_resp_c     = RESP_SLVERR;
      wr_scratch_c  = 1'b0;
      wr_control_c  = 1'b0;
      wr_irq_en_c   = 1'b0;
      wr_irq_stat_c = 1'b0;
`ifdef SC_OBC_SYSREG_UPTIME_EN
      wr_uptime_c   = 1'b0;
`endif
      if (hit(aw_idx, OFS_SCRATCH)) begin
         wr_resp_c    = RESP_OKAY;
         wr_scratch_c = commit_c;
      end else if (hit(aw_idx, OFS_CONTROL)) begin
         wr_resp_c    = RESP_OKAY;
         wr_control_c = commit_c;
      end else if (hit(aw_idx, OFS_IRQ_STAT)) begin
         wr_resp_c     = RESP_OKAY;
         wr_irq_stat_c = commit_c;
      end else if (hit(aw_idx, OFS_IRQ_EN)) begin
         wr_resp_c   = RESP_OKAY;
         wr_irq_en_c = commit_c;
      end
`ifdef SC_OBC_SYSREG_UPTIME_EN
      else if (hit(aw_idx, OFS_UPTIME)) begin
         wr_resp_c   = RESP_OKAY;
         wr_uptime_c = commit_c;
      end
`endif
      irq_clr_c = wr_irq_stat_c ? NUM_IRQ'(w_data & strb_mask(w_strb)) : '0;
   end

   // Read mux; sampled into RDATA on the AR handshake, so it sees pre-write values.
   always_comb begin
      ar_idx_c  = S_AXI_ARADDR[ADDR_W-1:2];
      rd_data_c = '0;
      rd_resp_c = RESP_OKAY;
      if (hit(ar_idx_c, OFS_VERSION))       rd_data_c = VERSION;
      else if (hit(ar_idx_c, OFS_SCRATCH))  rd_data_c = scratch;
      else if (hit(ar_idx_c, OFS_CONTROL))  rd_data_c = control;
      else if (hit(ar_idx_c, OFS_STATUS))   rd_data_c = STATUS_IN;
      else if (hit(ar_idx_c, OFS_IRQ_STAT)) rd_data_c = 32'(irq_stat);
      else if (hit(ar_idx_c, OFS_IRQ_EN))   rd_data_c = 32'(irq_en);
`ifdef SC_OBC_SYSREG_UPTIME_EN
      else if (hit(ar_idx_c, OFS_UPTIME))   rd_data_c = uptime;
`endif
      else                                  rd_resp_c = RESP_SLVERR;
   end

   // Channel state, holding buffers and RW registers.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         aw_full       <= 1'b0;
         w_full        <= 1'b0;
         aw_idx        <= '0;
         w_data        <= '0;
         w_strb        <= '0;
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_BRESP   <= RESP_OKAY;
         S_AXI_ARREADY <= 1'b0;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RDATA   <= '0;
         S_AXI_RRESP   <= RESP_OKAY;
         scratch       <= '0;
         control       <= CTRL_RST;
         irq_en        <= '0;
      end else begin
         aw_full       <= aw_full_nx_c;
         w_full        <= w_full_nx_c;
         S_AXI_AWREADY <= !aw_full_nx_c;
         S_AXI_WREADY  <= !w_full_nx_c;
         S_AXI_BVALID  <= bvalid_nx_c;
         S_AXI_RVALID  <= rvalid_nx_c;
         S_AXI_ARREADY <= !rvalid_nx_c;
         if (aw_hs_c) aw_idx <= S_AXI_AWADDR[ADDR_W-1:2];
         if (w_hs_c) begin
            w_data <= S_AXI_WDATA;
            w_strb <= S_AXI_WSTRB;
         end
         if (commit_c) S_AXI_BRESP <= wr_resp_c;
         if (ar_hs_c) begin
            S_AXI_RDATA <= rd_data_c;
            S_AXI_RRESP <= rd_resp_c;
         end
         if (wr_scratch_c) scratch <= strb_merge(scratch, w_data, w_strb);
         if (wr_control_c) control <= strb_merge(control, w_data, w_strb);
         if (wr_irq_en_c)  irq_en  <= NUM_IRQ'(strb_merge(32'(irq_en), w_data, w_strb));
      end
   end

`ifdef SC_OBC_SYSREG_UPTIME_EN
   // Free-running uptime counter; any committed write clears it.
   always_ff @(posedge CLK) begin
      if (RESET)            uptime <= '0;
      else if (wr_uptime_c) uptime <= '0;
      else                  uptime <= uptime + 32'd1;
   end
`endif

   sc_obc_irq_capture #(.NUM_IRQ(NUM_IRQ)) u_irq (
      .clk    (CLK),
      .reset  (RESET),
      .irq_in (IRQ_IN),
      .clr    (irq_clr_c),
      .en     (irq_en),
      .stat   (irq_stat),
      .irq    (IRQ)
   );

endmodule
